// File: rtl/layer_sdram_pkg.sv
// Shared types and helpers for the layer SDRAM read arbiter.
// Holds the FSM state enum, line width and a round-robin pick function.
package layer_sdram_pkg;

  localparam int LINE_BITS = 64;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HIT,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan last+1 .. last+n (mod n), return the first requester.
  function automatic rr_pick_t rr_pick(
    input logic [7:0] req,
    input logic [2:0] last,
    input int         n
  );
    rr_pick_t r;
    int       c;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      c = (int'(last) + k) % n;
      if (k <= n && !r.found && req[3'(c)]) begin
        r.found = 1'b1;
        r.idx   = 3'(c);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/layer_sdram_rr_pick.sv
// Combinational round-robin priority selector (up to 8 requesters).
// Ports: req/last in; grant index and found flag out.
module layer_sdram_rr_pick
  import layer_sdram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last,
  output logic [IW-1:0]     grant,
  output logic              found
);

  rr_pick_t p;

  always_comb begin
    p     = rr_pick(8'(req), 3'(last), NUM_CH);
    grant = IW'(p.idx);
    found = p.found;
  end

endmodule

// File: rtl/layer_sdram_arb.sv
// N-channel layer fetch arbiter onto one 64-bit SDRAM read port.
// Ports: CLK_32M/RESET; ch_* client side; sdr_* SDRAM side; paused, busy.
module layer_sdram_arb
  import layer_sdram_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_AW  = 20,
  parameter int DW     = 32,
  parameter int SDR_AW = 24,
  parameter logic [NUM_CH*SDR_AW-1:0] BASE_ADDRS = '0
) (
  input  logic                    CLK_32M,
  input  logic                    RESET,
  input  logic [NUM_CH*CH_AW-1:0] ch_addr,
  input  logic [NUM_CH-1:0]       ch_req,
  output logic [NUM_CH-1:0]       ch_rdy,
  output logic [DW-1:0]           ch_data,
  output logic [SDR_AW:1]         sdr_addr,
  output logic                    sdr_req,
  input  logic                    sdr_rdy,
  input  logic [63:0]             sdr_data,
  input  logic                    paused,
  output logic                    busy
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SH = (DW == 64) ? 2 : 1;

  arb_state_t state, state_nx;

  logic [IW-1:0]        rr_last, g_q, pick;
  logic                 found, grant;
  logic [NUM_CH-1:0]    pend, cand;
  logic [CH_AW-1:0]     pa;
  logic [SDR_AW-1:0]    pbase, full, aligned;
  logic                 psel, hit, sel_q;
  logic [SDR_AW-1:0]    addr_q, cache_tag;
  logic [LINE_BITS-1:0] cache_line;
  logic                 cache_valid;

  function automatic logic [DW-1:0] word_of(
    input logic [63:0] line,
    input logic        s
  );
    logic [63:0] w;
    w = s ? {32'b0, line[63:32]} : line;
    return DW'(w);
  endfunction

  // A channel just handed ch_rdy sits out one IDLE scan.
  assign cand = ch_req & ~(ch_rdy | pend);

  layer_sdram_rr_pick #(
    .NUM_CH(NUM_CH),
    .IW    (IW)
  ) u_pick (
    .req  (cand),
    .last (rr_last),
    .grant(pick),
    .found(found)
  );

  always_comb begin
    pa      = ch_addr[pick*CH_AW +: CH_AW];
    pbase   = BASE_ADDRS[pick*SDR_AW +: SDR_AW];
    full    = pbase + SDR_AW'({pa, {SH{1'b0}}});
    aligned = full & ~SDR_AW'(3);
    psel    = (DW == 32) && full[1];
    hit     = cache_valid && (aligned == cache_tag);
    grant   = (state == IDLE) && !paused && found;
  end

  assign sdr_addr = addr_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (grant) state_nx = hit ? HIT : FETCH;
      FETCH:     if (sdr_rdy) state_nx = DONE;
      HIT, DONE: state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      rr_last     <= IW'(NUM_CH - 1);
      g_q         <= '0;
      sel_q       <= 1'b0;
      addr_q      <= '0;
      sdr_req     <= 1'b0;
      ch_rdy      <= '0;
      ch_data     <= '0;
      pend        <= '0;
      cache_line  <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
    end else begin
      pend   <= (state == DONE) ? ch_rdy : '0;
      ch_rdy <= '0;
      if (grant) begin
        g_q     <= pick;
        rr_last <= pick;
        sel_q   <= psel;
        addr_q  <= aligned;
        sdr_req <= !hit;
      end
      if (state == FETCH && sdr_rdy) begin
        cache_line  <= sdr_data;
        cache_tag   <= addr_q;
        cache_valid <= 1'b1;
        sdr_req     <= 1'b0;
        ch_rdy      <= NUM_CH'(1) << g_q;
        ch_data     <= word_of(sdr_data, sel_q);
      end
      if (state == HIT) begin
        ch_rdy  <= NUM_CH'(1) << g_q;
        ch_data <= word_of(cache_line, sel_q);
      end
    end
  end

endmodule

// File: tb/tb_layer_sdram_arb.sv
// Bench for layer_sdram_arb: directed scenarios plus randomized traffic.
// Expected values come from an address/round-robin/cache model.
module tb_layer_sdram_arb;

  localparam int N   = 4;
  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int SAW = 24;
  localparam logic [N*SAW-1:0] BASES =
    {24'h200000, 24'h000000, 24'hFFFFF8, 24'h100000};

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N-1:0]    ch_req = '0;
  logic [N-1:0]    ch_rdy;
  logic [DW-1:0]   ch_data;
  logic [SAW:1]    sdr_addr;
  logic            sdr_req;
  logic            sdr_rdy = 1'b0;
  logic [63:0]     sdr_data = '0;
  logic            paused = 1'b0;
  logic            busy;

  int tests = 0;
  int fails = 0;

  int          m_last, m_excl;
  bit          m_cv;
  logic [23:0] m_tag;
  logic [63:0] m_line;
  logic [19:0] a_m [N];
  logic [3:0]  obs_q [$];
  int unsigned base [N] = '{32'h100000, 32'hFFFFF8, 32'h0, 32'h200000};

  layer_sdram_arb #(
    .NUM_CH    (N),
    .CH_AW     (AW),
    .DW        (DW),
    .SDR_AW    (SAW),
    .BASE_ADDRS(BASES)
  ) dut (
    .CLK_32M (clk),
    .RESET   (rst),
    .ch_addr (ch_addr),
    .ch_req  (ch_req),
    .ch_rdy  (ch_rdy),
    .ch_data (ch_data),
    .sdr_addr(sdr_addr),
    .sdr_req (sdr_req),
    .sdr_rdy (sdr_rdy),
    .sdr_data(sdr_data),
    .paused  (paused),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [19:0] v);
    ch_addr[i*AW +: AW] = v;
    a_m[i] = v;
  endtask

  function automatic logic [23:0] ef(input int ch, input logic [19:0] a);
    int unsigned s;
    s = base[ch] + 2 * int'(a);
    return 24'(s % 32'h100_0000);
  endfunction

  function automatic logic [23:0] ealign(input int ch, input logic [19:0] a);
    return ef(ch, a) - (ef(ch, a) % 4);
  endfunction

  function automatic bit esel(input int ch, input logic [19:0] a);
    return ((ef(ch, a) / 2) % 2) == 1;
  endfunction

  function automatic logic [31:0] eword(input logic [63:0] l, input bit s);
    return s ? l[63:32] : l[31:0];
  endfunction

  function automatic bit ehit(input int ch);
    return m_cv && (m_tag == ealign(ch, a_m[ch]));
  endfunction

  function automatic int pred(input logic [3:0] req);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (m_last + k) % N;
      if (req[c] && c != m_excl) return c;
    end
    return -1;
  endfunction

  task automatic reset_model;
    m_last = N - 1;
    m_excl = -1;
    m_cv   = 0;
  endtask

  function automatic logic [19:0] miss_addr(input int ch);
    logic [19:0] a;
    a = 20'($urandom);
    if (m_cv && m_tag == ealign(ch, a)) a = a ^ 20'h80;
    return a;
  endfunction

  task automatic serve(input int n, input bit all);
    logic [3:0]  req;
    int          g;
    logic [23:0] al;
    bit          s, h;
    logic [63:0] d;
    for (int t = 0; t < n; t++) begin
      req = all ? 4'hF : 4'($urandom_range(1, 15));
      if (m_excl >= 0 && req == 4'(1 << m_excl))
        req = req | 4'(1 << ((m_excl + 1) % N));
      ch_req = req;
      g  = pred(req);
      al = ealign(g, a_m[g]);
      s  = esel(g, a_m[g]);
      h  = ehit(g);
      m_last = g;
      tick;
      if (!h) begin
        tests++;
        if (sdr_req !== 1'b1) begin
          fails++;
          $display("FAIL serve_req t=%0d got %b exp 1", t, sdr_req);
        end
        tests++;
        if (sdr_addr !== al) begin
          fails++;
          $display("FAIL serve_addr t=%0d got %h exp %h", t, sdr_addr, al);
        end
        repeat ($urandom_range(0, 2)) tick;
        d = {$urandom, $urandom};
        sdr_data = d;
        sdr_rdy  = 1'b1;
        tick;
        sdr_rdy = 1'b0;
        m_cv   = 1;
        m_tag  = al;
        m_line = d;
      end else begin
        tests++;
        if (sdr_req !== 1'b0) begin
          fails++;
          $display("FAIL serve_hit_req t=%0d got %b exp 0", t, sdr_req);
        end
        tick;
      end
      tests++;
      if (ch_rdy !== 4'(1 << g)) begin
        fails++;
        $display("FAIL serve_rdy t=%0d got %b exp %b", t, ch_rdy, 4'(1 << g));
      end
      tests++;
      if (ch_data !== eword(m_line, s)) begin
        fails++;
        $display("FAIL serve_data t=%0d got %h exp %h", t, ch_data,
                 eword(m_line, s));
      end
      obs_q.push_back(ch_rdy);
      set_addr(g, ($urandom_range(0, 1) == 1) ? (a_m[g] ^ 20'h1)
                                                : 20'($urandom));
      if (!h) tick;
      m_excl = g;
    end
    ch_req = '0;
    tick;
    m_excl = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    tests++;
    if (ch_rdy !== '0) begin
      fails++; $display("FAIL rst_rdy got %b exp 0", ch_rdy);
    end
    tests++;
    if (ch_data !== '0) begin
      fails++; $display("FAIL rst_data got %h exp 0", ch_data);
    end
    tests++;
    if (sdr_req !== 1'b0) begin
      fails++; $display("FAIL rst_req got %b exp 0", sdr_req);
    end
    tests++;
    if (sdr_addr !== '0) begin
      fails++; $display("FAIL rst_addr got %h exp 0", sdr_addr);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL rst_busy got %b exp 0", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    tick;
  endtask

  task automatic test_single_miss;
    set_addr(0, 20'h00005);
    ch_req = 4'b0001;
    tick;
    tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h100008) begin
      fails++;
      $display("FAIL miss_addr got req=%b addr=%h exp req=1 addr=100008",
               sdr_req, sdr_addr);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL miss_busy got %b exp 1", busy);
    end
    tick;
    tests++;
    if (sdr_req !== 1'b1) begin
      fails++; $display("FAIL miss_hold got %b exp 1", sdr_req);
    end
    sdr_data = 64'hAAAA_BBBB_CCCC_DDDD;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b0001 || ch_data !== 32'hAAAA_BBBB) begin
      fails++;
      $display("FAIL miss_resp got rdy=%b data=%h exp rdy=0001 data=aaaabbbb",
               ch_rdy, ch_data);
    end
    tests++;
    if (sdr_req !== 1'b0) begin
      fails++; $display("FAIL miss_req_drop got %b exp 0", sdr_req);
    end
    ch_req = '0;
    tick;
    tests++;
    if (ch_rdy !== '0) begin
      fails++; $display("FAIL miss_pulse got %b exp 0", ch_rdy);
    end
    m_cv = 1; m_tag = 24'h100008; m_line = 64'hAAAA_BBBB_CCCC_DDDD;
    m_last = 0;
    tick;
    m_excl = -1;
  endtask

  task automatic test_cache_hit;
    set_addr(0, 20'h00004);
    ch_req = 4'b0001;
    tick;
    tests++;
    if (sdr_req !== 1'b0 || ch_rdy !== '0) begin
      fails++;
      $display("FAIL hit_early got req=%b rdy=%b exp req=0 rdy=0",
               sdr_req, ch_rdy);
    end
    tick;
    tests++;
    if (ch_rdy !== 4'b0001 || ch_data !== 32'hCCCC_DDDD) begin
      fails++;
      $display("FAIL hit_resp got rdy=%b data=%h exp rdy=0001 data=ccccdddd",
               ch_rdy, ch_data);
    end
    ch_req = '0;
    tick;
    m_last = 0;
    m_excl = -1;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    #2;
    rst = 1'b0;
    reset_model();
    for (int i = 0; i < N; i++) set_addr(i, 20'($urandom));
    obs_q.delete();
    serve(5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (obs_q[i] !== 4'(1 << order[i])) begin
        fails++;
        $display("FAIL rr_order i=%0d got %b exp %b", i, obs_q[i],
                 4'(1 << order[i]));
      end
    end
  endtask

  task automatic test_random;
    serve(40, 1'b0);
  endtask

  task automatic test_pause;
    logic [63:0] d;
    set_addr(0, miss_addr(0));
    ch_req = 4'b0001;
    tick;
    m_last = 0;
    tests++;
    if (sdr_req !== 1'b1) begin
      fails++; $display("FAIL pause_req got %b exp 1", sdr_req);
    end
    paused = 1'b1;
    tick;
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b0001 ||
        ch_data !== eword(d, esel(0, a_m[0]))) begin
      fails++;
      $display("FAIL pause_inflight got rdy=%b data=%h exp rdy=0001 data=%h",
               ch_rdy, ch_data, eword(d, esel(0, a_m[0])));
    end
    m_cv = 1; m_tag = ealign(0, a_m[0]); m_line = d;
    set_addr(1, miss_addr(1));
    ch_req = 4'b0010;
    tick;
    for (int i = 0; i < 4; i++) begin
      sdr_rdy = (i == 1);
      tick;
      sdr_rdy = 1'b0;
      tests++;
      if (busy !== 1'b0 || sdr_req !== 1'b0 || ch_rdy !== '0) begin
        fails++;
        $display("FAIL pause_hold i=%0d got busy=%b req=%b rdy=%b exp 0 0 0",
                 i, busy, sdr_req, ch_rdy);
      end
    end
    paused = 1'b0;
    tick;
    m_last = 1;
    tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== ealign(1, a_m[1])) begin
      fails++;
      $display("FAIL pause_resume got req=%b addr=%h exp req=1 addr=%h",
               sdr_req, sdr_addr, ealign(1, a_m[1]));
    end
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b0010) begin
      fails++; $display("FAIL pause_rdy1 got %b exp 0010", ch_rdy);
    end
    m_cv = 1; m_tag = ealign(1, a_m[1]); m_line = d;
    ch_req = '0;
    tick;
    tick;
    m_excl = -1;
  endtask

  task automatic test_drop;
    logic [63:0] d;
    set_addr(3, miss_addr(3));
    ch_req = 4'b1000;
    tick;
    m_last = 3;
    ch_req = '0;
    tick;
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b1000) begin
      fails++; $display("FAIL drop_rdy got %b exp 1000", ch_rdy);
    end
    m_cv = 1; m_tag = ealign(3, a_m[3]); m_line = d;
    tick;
    tick;
    ch_req = 4'b1000;
    tick;
    tests++;
    if (sdr_req !== 1'b0) begin
      fails++; $display("FAIL drop_cached got req=%b exp 0", sdr_req);
    end
    tick;
    tests++;
    if (ch_rdy !== 4'b1000 || ch_data !== eword(d, esel(3, a_m[3]))) begin
      fails++;
      $display("FAIL drop_hit got rdy=%b data=%h exp rdy=1000 data=%h",
               ch_rdy, ch_data, eword(d, esel(3, a_m[3])));
    end
    ch_req = '0;
    tick;
    m_excl = -1;
  endtask

  task automatic test_reset_mid_fetch;
    logic [63:0] d;
    set_addr(2, miss_addr(2));
    ch_req = 4'b0100;
    tick;
    tests++;
    if (sdr_req !== 1'b1) begin
      fails++; $display("FAIL rmf_req got %b exp 1", sdr_req);
    end
    ch_req = '0;
    rst = 1'b1;
    #1;
    tests++;
    if (sdr_req !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rmf_async got req=%b busy=%b exp 0 0", sdr_req, busy);
    end
    #1;
    rst = 1'b0;
    reset_model();
    ch_req = 4'b1000;
    tick;
    m_last = 3;
    tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== ealign(3, a_m[3])) begin
      fails++;
      $display("FAIL rmf_invalid got req=%b addr=%h exp req=1 addr=%h",
               sdr_req, sdr_addr, ealign(3, a_m[3]));
    end
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b1000) begin
      fails++; $display("FAIL rmf_rdy got %b exp 1000", ch_rdy);
    end
    m_cv = 1; m_tag = ealign(3, a_m[3]); m_line = d;
    ch_req = '0;
    tick;
    tick;
    m_excl = -1;
  endtask

  task automatic test_base_wrap;
    logic [63:0] d;
    set_addr(1, 20'h00008);
    ch_req = 4'b0010;
    tick;
    m_last = 1;
    tests++;
    if (sdr_req !== 1'b1 || sdr_addr !== 24'h000008) begin
      fails++;
      $display("FAIL wrap_addr got req=%b addr=%h exp req=1 addr=000008",
               sdr_req, sdr_addr);
    end
    tests++;
    if (sdr_addr !== ealign(1, a_m[1])) begin
      fails++;
      $display("FAIL wrap_model got %h exp %h", sdr_addr, ealign(1, a_m[1]));
    end
    d = {$urandom, $urandom};
    sdr_data = d;
    sdr_rdy  = 1'b1;
    tick;
    sdr_rdy = 1'b0;
    tests++;
    if (ch_rdy !== 4'b0010 || ch_data !== eword(d, esel(1, a_m[1]))) begin
      fails++;
      $display("FAIL wrap_lo got rdy=%b data=%h exp rdy=0010 data=%h",
               ch_rdy, ch_data, eword(d, esel(1, a_m[1])));
    end
    m_cv = 1; m_tag = ealign(1, a_m[1]); m_line = d;
    tick;
    tick;
    set_addr(1, 20'h00009);
    tick;
    tests++;
    if (sdr_req !== 1'b0) begin
      fails++; $display("FAIL wrap_hit_req got %b exp 0", sdr_req);
    end
    tick;
    tests++;
    if (ch_rdy !== 4'b0010 || ch_data !== eword(d, esel(1, a_m[1]))) begin
      fails++;
      $display("FAIL wrap_hi got rdy=%b data=%h exp rdy=0010 data=%h",
               ch_rdy, ch_data, eword(d, esel(1, a_m[1])));
    end
    ch_req = '0;
    tick;
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_cache_hit();
    test_round_robin();
    test_random();
    test_pause();
    test_drop();
    test_reset_mid_fetch();
    test_base_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer_sdram_arb.md
Name: layer_sdram_arb

Overview:
- Parametrised N-channel read arbiter between tile/sprite layer fetchers and one 64-bit SDRAM read port.
- Generalises the fixed two-channel (layer A/B) ROM fetch path, so one board can carry any number of layers.
- Adds round-robin fairness, per-channel ROM base offsets, DW-wide word selection, a one-entry line cache and pause gating.
- Sits between the layer instances and the board-level SDRAM request interface.

Parameters:
- NUM_CH, 2, number of client channels (1..8).
- CH_AW, 20, client word-address width.
- DW, 32, client data width; 32 or 64 only.
- SDR_AW, 24, SDRAM 16-bit-word address width; the port is [SDR_AW:1].
- BASE_ADDRS, 0, NUM_CH*SDR_AW flattened per-channel SDRAM word base. Channel i occupies bits [i*SDR_AW +: SDR_AW].

Ports:
- CLK_32M  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ch_addr  in  NUM_CH*CH_AW  client word addresses, packed per channel.
- ch_req  in  NUM_CH  level request; held with ch_addr stable until ch_rdy.
- ch_rdy  out  NUM_CH  one-cycle completion pulse per channel.
- ch_data  out  DW  returned data, broadcast; valid in the ch_rdy cycle.
- sdr_addr  out  SDR_AW  64-bit-aligned SDRAM word address, bits [SDR_AW:1].
- sdr_req  out  1  level request; held until sdr_rdy.
- sdr_rdy  in  1  one-cycle pulse; sdr_data valid in the same cycle.
- sdr_data  in  64  SDRAM read data.
- paused  in  1  blocks new grants.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE, ch_rdy = 0, ch_data = 0, sdr_req = 0, sdr_addr = 0, busy = 0.
  - cache_valid = 0.
  - rr_last = NUM_CH-1, so channel 0 wins first.
- Address arithmetic, for granted channel g:
  - word_off = ch_addr[g] * (DW/16).
  - full = BASE_ADDRS[g] + word_off, computed modulo 2^SDR_AW; overflow wraps silently.
  - sdr_addr = full with bits [2:1] forced to 0.
  - For DW=32, sel = full[2]: 0 returns sdr_data[31:0], 1 returns sdr_data[63:32].
- Arbitration (IDLE only, paused=0):
  - Scan channels rr_last+1 .. rr_last+NUM_CH modulo NUM_CH.
  - The first channel with ch_req=1 and not already serviced-pending is granted.
  - rr_last is set to g on grant.
  - Simultaneous requests therefore rotate; no channel waits more than NUM_CH-1 transactions.
- FSM:
  - IDLE:
    - No request → stay in IDLE.
    - Grant and cache hit (cache_valid, aligned address == cache_tag) → HIT.
    - Grant and miss → FETCH: latch g, sel and aligned address; sdr_req = 1 next cycle.
  - FETCH:
    - Hold sdr_req and sdr_addr.
    - On sdr_rdy: cache_line = sdr_data, cache_tag = aligned address, cache_valid = 1; sdr_req = 0 → DONE.
  - HIT / DONE:
    - ch_rdy[g] = 1 for exactly one cycle; ch_data = selected word.
    - Next state is IDLE.
- Latency:
  - Hit: ch_req seen at edge N, ch_rdy high in cycle N+2.
  - Miss: sdr_req high from N+1; sdr_rdy at cycle M gives ch_rdy at M+1.
- Serviced-pending:
  - A channel that received ch_rdy is excluded from the scan during the following IDLE cycle.
  - This lets the client drop or re-issue ch_req without a duplicate grant.
- Boundary cases:
  - Client drops ch_req mid-FETCH: the transaction still completes, cache updates, ch_rdy pulses (client ignores it).
  - paused=1: no grant in IDLE. In-flight FETCH/DONE/HIT complete normally. sdr_req never rises while paused in IDLE.
  - sdr_rdy while not in FETCH: ignored.
  - NUM_CH=1: rotation is trivial; behaviour is otherwise unchanged.
  - RESET asserted mid-FETCH: sdr_req drops asynchronously and the cache is invalidated. The downstream controller must tolerate an abandoned request.

Decomposition:
- Package layer_sdram_pkg holds:
  - state enum arb_state_t {IDLE, FETCH, HIT, DONE};
  - function rr_pick(req, last, n) returning the grant index and a found flag;
  - constant LINE_BITS = 64.
- One sub-module, layer_sdram_rr_pick: a purely combinational round-robin priority selector. It is reused by future sprite-DMA arbiters.

Test Plan:
- Single miss:
  - Stimulus: NUM_CH=2, DW=32, BASE0=0x100000, ch_addr0=0x00005, ch_req0=1.
  - Response: sdr_addr=0x10000A→aligned 0x100008; sdr_rdy with data 0xAAAA_BBBB_CCCC_DDDD; ch_data=0xAAAA_BBBB (sel=1); ch_rdy[0] one cycle, one cycle after sdr_rdy.
- Cache hit:
  - Stimulus: immediately request ch_addr0=0x00004.
  - Response: no sdr_req; ch_rdy[0] two cycles after the request with ch_data=0xCCCC_DDDD.
- Round-robin:
  - Stimulus: NUM_CH=4, all ch_req held high, distinct lines.
  - Response: grant order 0,1,2,3,0; no channel granted twice before the others.
- Pause:
  - Stimulus: paused=1 asserted during FETCH.
  - Response: the current ch_rdy still fires; no further sdr_req until paused=0; busy=0 while held.
- Reset mid-FETCH:
  - Stimulus: RESET pulse while sdr_req=1.
  - Response: sdr_req=0 immediately (async). A repeat of the prior address misses, because the cache is invalid. Channel 0 wins first.
- Base wrap:
  - Stimulus: SDR_AW=24, BASE=0xFFFFF8, ch_addr=8, DW=32.
  - Response: sdr_addr=0x000008, wrapping modulo 2^24.
